// File: rtl/bridge_timer_pkg.sv
// Shared definitions for the bridge timer peripheral: register map, CTRL
// field positions, FSM states and timer modes.
package bridge_timer_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  // Only the low nibble of CTRL is implemented; upper bits read back as zero.
  localparam logic [31:0] CTRL_WMASK = 32'h0000_000F;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } tmr_state_e;

endpackage

// File: rtl/bridge_timer_be_merge.sv
// Byte-enable merge of a 32-bit register value with bus write data; shared
// by bridge-bus responders.
module be_merge (
  input  logic [31:0] old_i,
  input  logic [31:0] new_i,
  input  logic [3:0]  be_i,
  output logic [31:0] merged_o
);

  always_comb begin
    merged_o = old_i;
    for (int i = 0; i < 4; i++) begin
      if (be_i[i]) merged_o[8*i +: 8] = new_i[8*i +: 8];
    end
  end

endmodule

// File: rtl/bridge_timer.sv
// Bridge-bus timer/counter: CTRL/PRESET/COUNT registers, countdown FSM with
// one-shot and auto-reload modes, and a masked level interrupt.
module bridge_timer
  import bridge_timer_pkg::*;
#(
  parameter logic [31:0] PRESET_RST = 32'h0000_0000,
  parameter logic [31:0] CTRL_RST   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq
);

  logic [31:0] ctrl_q, ctrl_d, ctrl_fsm, ctrl_merged;
  logic [31:0] preset_q, preset_d, preset_merged;
  logic [31:0] count_q;
  logic        pend_q;
  tmr_state_e  state_q;

  logic wr_ctrl, wr_preset;
  logic en, reload;

  assign wr_ctrl   = we && (addr == ADDR_CTRL);
  assign wr_preset = we && (addr == ADDR_PRESET);
  assign en        = ctrl_q[CTRL_EN];
  assign reload    = (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);

  // The merge is applied on top of the FSM's EN auto-clear so that a CPU
  // write to byte 0 in the same cycle overrides it.
  be_merge u_ctrl_merge (
    .old_i   (ctrl_fsm),
    .new_i   (wd),
    .be_i    (be),
    .merged_o(ctrl_merged)
  );

  be_merge u_preset_merge (
    .old_i   (preset_q),
    .new_i   (wd),
    .be_i    (be),
    .merged_o(preset_merged)
  );

  always_comb begin
    ctrl_fsm = ctrl_q;
    if (state_q == INT && !reload) ctrl_fsm[CTRL_EN] = 1'b0;
    ctrl_d   = wr_ctrl ? (ctrl_merged & CTRL_WMASK) : ctrl_fsm;
    preset_d = wr_preset ? preset_merged : preset_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q   <= CTRL_RST & CTRL_WMASK;
      preset_q <= PRESET_RST;
      count_q  <= 32'd0;
      pend_q   <= 1'b0;
      state_q  <= IDLE;
    end else begin
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      // Later assignments win: the INT-state set overrides a write clear.
      if (wr_ctrl || wr_preset) pend_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (en) state_q <= LOAD;
        end
        LOAD: begin
          count_q <= preset_q;
          pend_q  <= 1'b0;
          state_q <= CNT;
        end
        CNT: begin
          if (!en) begin
            state_q <= IDLE;
          end else if (count_q > 32'd1) begin
            count_q <= count_q - 32'd1;
          end else begin
            count_q <= 32'd0;
            state_q <= INT;
          end
        end
        INT: begin
          pend_q  <= 1'b1;
          state_q <= reload ? LOAD : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    case (addr)
      ADDR_CTRL:   rd = ctrl_q;
      ADDR_PRESET: rd = preset_q;
      ADDR_COUNT:  rd = count_q;
      default:     rd = 32'd0;
    endcase
  end

  assign irq = pend_q & ctrl_q[CTRL_IM];

endmodule

// File: tb/tb_bridge_timer.sv
// Bench for bridge_timer: directed scenarios plus randomized register traffic,
// all checked against a cycle-level behavioural model of the timer.
module tb_bridge_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  bridge_timer dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .we   (we),
    .be   (be),
    .wd   (wd),
    .rd   (rd),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 loading, 2 counting down, 3 firing.
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset, m_count;
  bit          m_pend;
  int          m_phase;

  function automatic logic [31:0] bytes_merge(input logic [31:0] o, input logic [31:0] n,
                                              input logic [3:0] b);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_ctrl = 4'h0; m_preset = 32'h0; m_count = 32'h0; m_pend = 0; m_phase = 0;
  endtask

  task automatic model_step(input bit w, input logic [1:0] a, input logic [3:0] b,
                            input logic [31:0] d);
    logic [3:0]  ctrl_n;
    logic [31:0] preset_n, count_n, tmp;
    bit          pend_n, en, rel, wc, wp;
    int          phase_n;
    ctrl_n = m_ctrl; preset_n = m_preset; count_n = m_count;
    pend_n = m_pend; phase_n = m_phase;
    en  = m_ctrl[0];
    rel = (m_ctrl[2:1] == 2'd1);
    wc  = w && (a == 2'd0);
    wp  = w && (a == 2'd1);
    if (wc || wp) pend_n = 0;
    case (m_phase)
      0: if (en) phase_n = 1;
      1: begin count_n = m_preset; pend_n = 0; phase_n = 2; end
      2: begin
        if (!en) phase_n = 0;
        else if (m_count > 1) count_n = m_count - 1;
        else begin count_n = 0; phase_n = 3; end
      end
      default: begin
        pend_n = 1;
        if (rel) phase_n = 1;
        else begin phase_n = 0; ctrl_n[0] = 1'b0; end
      end
    endcase
    if (wc) begin
      tmp = bytes_merge({28'h0, ctrl_n}, d, b);
      ctrl_n = tmp[3:0];
    end
    if (wp) preset_n = bytes_merge(m_preset, d, b);
    m_ctrl = ctrl_n; m_preset = preset_n; m_count = count_n;
    m_pend = pend_n; m_phase = phase_n;
  endtask

  task automatic check_all();
    logic [31:0] exp;
    for (int a = 0; a < 4; a++) begin
      addr = a[1:0];
      #1;
      case (a)
        0: exp = {28'h0, m_ctrl};
        1: exp = m_preset;
        2: exp = m_count;
        default: exp = 32'h0;
      endcase
      check($sformatf("rd[%0d]", a), rd, exp);
    end
    check("irq", {31'h0, irq}, {31'h0, m_pend & m_ctrl[3]});
  endtask

  task automatic cycle(input bit w, input logic [1:0] a, input logic [3:0] b, input logic [31:0] d);
    we = w; addr = a; be = b; wd = d;
    @(posedge clk);
    model_step(w, a, b, d);
    #1;
    we = 1'b0;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, 4'h0, 32'h0);
  endtask

  task automatic peek(input logic [1:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rd;
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] exp_cnt [8];
    int          irq_hi;

    reset = 1'b1; we = 1'b0; addr = 2'd0; be = 4'h0; wd = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    reset = 1'b0;

    // One-shot countdown from 5 with interrupt unmasked.
    exp_cnt = '{32'd0, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0};
    cycle(1'b1, 2'd1, 4'hF, 32'd5);
    cycle(1'b1, 2'd0, 4'hF, 32'h9);
    for (int j = 0; j < 8; j++) begin
      cycle(1'b0, 2'd0, 4'h0, 32'h0);
      peek(2'd2, v);
      check($sformatf("oneshot_cnt%0d", j + 1), v, exp_cnt[j]);
      if (j == 6) check("oneshot_irq_early", {31'h0, irq}, 32'h0);
    end
    check("oneshot_irq", {31'h0, irq}, 32'h1);
    peek(2'd0, v);
    check("oneshot_en_clr", v, 32'h8);
    idle(2);
    check("oneshot_irq_held", {31'h0, irq}, 32'h1);

    // CTRL write clears the pending interrupt; timer remains idle.
    cycle(1'b1, 2'd0, 4'hF, 32'h8);
    check("clr_irq", {31'h0, irq}, 32'h0);
    idle(3);

    // Auto-reload: one-cycle pulse every five cycles.
    cycle(1'b1, 2'd1, 4'hF, 32'd3);
    cycle(1'b1, 2'd0, 4'hF, 32'hB);
    idle(5);
    irq_hi = 0;
    for (int j = 0; j < 20; j++) begin
      cycle(1'b0, 2'd0, 4'h0, 32'h0);
      if (irq) irq_hi++;
    end
    check("reload_pulses", irq_hi, 32'd4);

    // Asynchronous reset in the middle of counting.
    reset = 1'b1;
    #1;
    peek(2'd0, v); check("rst_ctrl", v, 32'h0);
    peek(2'd2, v); check("rst_count", v, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    model_reset();
    #1 reset = 1'b0;

    // Partial byte writes and writes to read-only / reserved addresses.
    cycle(1'b1, 2'd1, 4'b0011, 32'h1234_5678);
    peek(2'd1, v);
    check("be_preset", v, 32'h0000_5678);
    cycle(1'b1, 2'd2, 4'hF, 32'hDEAD_BEEF);
    cycle(1'b1, 2'd3, 4'hF, 32'hCAFE_F00D);
    peek(2'd3, v);
    check("rsvd_zero", v, 32'h0);

    // PRESET=0 behaves like PRESET=1.
    cycle(1'b1, 2'd1, 4'hF, 32'd0);
    cycle(1'b1, 2'd0, 4'hF, 32'h9);
    idle(6);
    cycle(1'b1, 2'd0, 4'hF, 32'h0);

    // Clearing EN mid-count freezes COUNT.
    cycle(1'b1, 2'd1, 4'hF, 32'd9);
    cycle(1'b1, 2'd0, 4'hF, 32'h9);
    idle(3);
    cycle(1'b1, 2'd0, 4'hF, 32'h8);
    for (int j = 0; j < 4; j++) begin
      cycle(1'b0, 2'd0, 4'h0, 32'h0);
      peek(2'd2, v);
      check("hold_cnt", v, 32'd7);
      check("hold_irq", {31'h0, irq}, 32'h0);
    end

    // Randomized register traffic, including collisions with INT and LOAD.
    for (int j = 0; j < 400; j++) begin
      if ($urandom_range(0, 3) == 0) begin
        logic [1:0]  ra;
        logic [31:0] rw;
        ra = 2'($urandom_range(0, 3));
        rw = $urandom();
        if (ra == 2'd1) rw = {rw[31:8], 8'($urandom_range(0, 7))};
        if (ra == 2'd1 && $urandom_range(0, 1) == 1) rw = 32'($urandom_range(0, 7));
        cycle(1'b1, ra, 4'($urandom_range(0, 15)), rw);
      end else begin
        cycle(1'b0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), $urandom());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
